// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix-multiply datapath blocks.
//   MATRIX_MEM_WIDTH_DEFAULT : default element width (two's complement)
//   NUM_LANES                : number of multiplier lanes feeding a beat
//   acc_state_t              : result accumulator control states
//   add_overflow()           : signed-add overflow from operand/result signs
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int MATRIX_MEM_WIDTH_DEFAULT = 32;
    localparam int NUM_LANES                = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Two's complement addition overflows only when both operands share a
    // sign and the wrapped result has the opposite sign.
    function automatic logic add_overflow(input logic a_sign,
                                          input logic b_sign,
                                          input logic sum_sign);
        return (a_sign == b_sign) && (sum_sign != a_sign);
    endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// -----------------------------------------------------------------------------
// lane_adder_tree
// Masks the lane products and sums them in a pairwise tree
// ((lane0+lane1) + (lane2+lane3)), registering the wrapped sum and a flag that
// is set if any adder node overflowed. One cycle of latency.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_valid      : lane data valid this cycle
//   i_mask       : bit i set = lane i contributes, otherwise it adds 0
//   i_lane       : lane products
//   o_valid      : registered i_valid
//   o_sum        : registered masked lane sum (wraps mod 2^WIDTH)
//   o_overflow   : registered signed-overflow flag for this sum
// -----------------------------------------------------------------------------
module lane_adder_tree
    import matrix_pkg::*;
#(
    parameter int WIDTH = MATRIX_MEM_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [NUM_LANES-1:0] i_mask,
    input  logic [WIDTH-1:0]     i_lane [NUM_LANES],
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_sum,
    output logic                 o_overflow
);

    logic [WIDTH-1:0] w_masked   [NUM_LANES];
    logic [WIDTH-1:0] w_pair     [NUM_LANES/2];
    logic             w_pair_ovf [NUM_LANES/2];
    logic [WIDTH-1:0] w_total;
    logic             w_total_ovf;

    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_overflow;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_mask
        assign w_masked[gi] = i_mask[gi] ? i_lane[gi] : '0;
    end

    for (genvar gi = 0; gi < NUM_LANES/2; gi++) begin : g_pair
        assign w_pair[gi]     = w_masked[2*gi] + w_masked[2*gi+1];
        assign w_pair_ovf[gi] = add_overflow(w_masked[2*gi][WIDTH-1],
                                             w_masked[2*gi+1][WIDTH-1],
                                             w_pair[gi][WIDTH-1]);
    end

    // Final node of the four-lane tree.
    assign w_total     = w_pair[0] + w_pair[1];
    assign w_total_ovf = w_pair_ovf[0] || w_pair_ovf[1] ||
                         add_overflow(w_pair[0][WIDTH-1], w_pair[1][WIDTH-1],
                                      w_total[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_sum      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sum      <= w_total;
                r_overflow <= w_total_ovf;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_sum      = r_sum;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/result_accumulator.sv
// -----------------------------------------------------------------------------
// result_accumulator
// Consumes four lane products per beat, sums the enabled lanes (stage 1),
// accumulates the dot product for one C element (stage 2) and writes each
// finished element to C memory in row-major order.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : one-cycle pulse arming a new matrix (IDLE/DONE only)
//   beat_valid, beat_last : beat strobe, final beat of the current element
//   lane_mask             : per-lane contribute enables
//   mult_1_out..mult_4_out: lane products
//   acc_ready             : high only in ACCUM; beats accepted only then
//   wr_en_c               : one-cycle C memory write strobe per element
//   wr_address_c          : C write address (holds when wr_en_c is low)
//   write_data_c          : finished element (holds when wr_en_c is low)
//   done_c                : level, all elements written
//   overflow_c            : sticky signed overflow in lane sum or accumulate
//   protocol_err          : sticky, beat_valid seen while acc_ready low
// -----------------------------------------------------------------------------
module result_accumulator
    import matrix_pkg::*;
#(
    parameter  int MATRIX_C_ROWS      = 8,
    parameter  int MATRIX_C_COLUMNS   = 8,
    parameter  int MATRIX_C_MEM_DEPTH = 64,
    parameter  int MATRIX_MEM_WIDTH   = MATRIX_MEM_WIDTH_DEFAULT,
    localparam int ADDR_W = $clog2(MATRIX_C_MEM_DEPTH),
    localparam int ROW_W  = (MATRIX_C_ROWS > 1) ? $clog2(MATRIX_C_ROWS) : 1,
    localparam int COL_W  = (MATRIX_C_COLUMNS > 1) ? $clog2(MATRIX_C_COLUMNS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        beat_valid,
    input  logic                        beat_last,
    input  logic [NUM_LANES-1:0]        lane_mask,
    input  logic [MATRIX_MEM_WIDTH-1:0] mult_1_out,
    input  logic [MATRIX_MEM_WIDTH-1:0] mult_2_out,
    input  logic [MATRIX_MEM_WIDTH-1:0] mult_3_out,
    input  logic [MATRIX_MEM_WIDTH-1:0] mult_4_out,
    output logic                        acc_ready,
    output logic                        wr_en_c,
    output logic [ADDR_W-1:0]           wr_address_c,
    output logic [MATRIX_MEM_WIDTH-1:0] write_data_c,
    output logic                        done_c,
    output logic                        overflow_c,
    output logic                        protocol_err
);

    acc_state_t                  r_state;
    logic                        r_s1_last;
    logic [MATRIX_MEM_WIDTH-1:0] r_acc;
    logic [ROW_W-1:0]            r_row;
    logic [COL_W-1:0]            r_col;
    logic [ADDR_W-1:0]           r_addr;
    logic                        r_wr_en;
    logic [ADDR_W-1:0]           r_wr_addr;
    logic [MATRIX_MEM_WIDTH-1:0] r_wr_data;
    logic                        r_done;
    logic                        r_overflow;
    logic                        r_protocol_err;

    logic [MATRIX_MEM_WIDTH-1:0] w_lane [NUM_LANES];
    logic                        w_acc_ready;
    logic                        w_accept;
    logic                        w_arm;
    logic                        w_s1_valid;
    logic [MATRIX_MEM_WIDTH-1:0] w_s1_sum;
    logic                        w_s1_ovf;
    logic [MATRIX_MEM_WIDTH-1:0] w_acc_sum;
    logic                        w_acc_ovf;
    logic                        w_last_elem;

    assign w_lane[0] = mult_1_out;
    assign w_lane[1] = mult_2_out;
    assign w_lane[2] = mult_3_out;
    assign w_lane[3] = mult_4_out;

    assign w_acc_ready = (r_state == ACCUM);
    assign w_accept    = beat_valid && w_acc_ready;
    // start is only honoured outside ACCUM.
    assign w_arm       = start && (r_state != ACCUM);

    lane_adder_tree #(
        .WIDTH (MATRIX_MEM_WIDTH)
    ) u_lane_adder_tree (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (w_accept),
        .i_mask     (lane_mask),
        .i_lane     (w_lane),
        .o_valid    (w_s1_valid),
        .o_sum      (w_s1_sum),
        .o_overflow (w_s1_ovf)
    );

    assign w_acc_sum = r_acc + w_s1_sum;
    assign w_acc_ovf = add_overflow(r_acc[MATRIX_MEM_WIDTH-1],
                                    w_s1_sum[MATRIX_MEM_WIDTH-1],
                                    w_acc_sum[MATRIX_MEM_WIDTH-1]);

    // Element currently being written is the bottom-right corner of C.
    assign w_last_elem = (r_row == ROW_W'(MATRIX_C_ROWS - 1)) &&
                         (r_col == COL_W'(MATRIX_C_COLUMNS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_s1_last      <= 1'b0;
            r_acc          <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_addr         <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_done         <= 1'b0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_s1_last <= w_accept && beat_last;

            // Stage 2 runs regardless of state so in-flight beats finish.
            if (w_s1_valid) begin
                if (w_s1_ovf || w_acc_ovf) begin
                    r_overflow <= 1'b1;
                end
                if (r_s1_last) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_wr_data <= w_acc_sum;
                    // Clearing here keeps a back-to-back beat from inheriting
                    // the finished element's sum.
                    r_acc     <= '0;
                    if (r_col == COL_W'(MATRIX_C_COLUMNS - 1)) begin
                        r_col <= '0;
                        r_row <= (r_row == ROW_W'(MATRIX_C_ROWS - 1)) ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    r_addr <= w_last_elem ? '0 : r_addr + 1'b1;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end

            if (beat_valid && !w_acc_ready) begin
                r_protocol_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_s1_valid && r_s1_last && w_last_elem) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                    if (start) begin
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Arming a new matrix overrides any update made above.
            if (w_arm) begin
                r_acc          <= '0;
                r_row          <= '0;
                r_col          <= '0;
                r_addr         <= '0;
                r_done         <= 1'b0;
                r_overflow     <= 1'b0;
                r_protocol_err <= 1'b0;
            end
        end
    end

    assign acc_ready    = w_acc_ready;
    assign wr_en_c      = r_wr_en;
    assign wr_address_c = r_wr_addr;
    assign write_data_c = r_wr_data;
    assign done_c       = r_done;
    assign overflow_c   = r_overflow;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_result_accumulator.sv
module tb_result_accumulator;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int AW    = 2;
    localparam int MAXC  = 3000;

    localparam int K_READY = 0;
    localparam int K_DONE  = 1;
    localparam int K_OVF   = 2;
    localparam int K_PERR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic          beat_valid = 1'b0;
    logic          beat_last = 1'b0;
    logic [3:0]    lane_mask = 4'h0;
    logic [W-1:0]  mult_1_out = '0;
    logic [W-1:0]  mult_2_out = '0;
    logic [W-1:0]  mult_3_out = '0;
    logic [W-1:0]  mult_4_out = '0;
    logic          acc_ready;
    logic          wr_en_c;
    logic [AW-1:0] wr_address_c;
    logic [W-1:0]  write_data_c;
    logic          done_c;
    logic          overflow_c;
    logic          protocol_err;

    always #5 clk = ~clk;

    result_accumulator #(
        .MATRIX_C_ROWS      (ROWS),
        .MATRIX_C_COLUMNS   (COLS),
        .MATRIX_C_MEM_DEPTH (DEPTH),
        .MATRIX_MEM_WIDTH   (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .beat_valid   (beat_valid),
        .beat_last    (beat_last),
        .lane_mask    (lane_mask),
        .mult_1_out   (mult_1_out),
        .mult_2_out   (mult_2_out),
        .mult_3_out   (mult_3_out),
        .mult_4_out   (mult_4_out),
        .acc_ready    (acc_ready),
        .wr_en_c      (wr_en_c),
        .wr_address_c (wr_address_c),
        .write_data_c (write_data_c),
        .done_c       (done_c),
        .overflow_c   (overflow_c),
        .protocol_err (protocol_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expected level of each status output, per cycle.
    bit exp_ready [MAXC];
    bit exp_done  [MAXC];
    bit exp_ovf   [MAXC];
    bit exp_perr  [MAXC];

    typedef struct {
        int addr;
        int data;
        int due;
    } wr_t;
    wr_t wq[$];

    int model_acc   = 0;
    int model_addr  = 0;
    int model_count = 0;
    int last_addr   = 0;
    int last_data   = 0;
    int cap_data [DEPTH];

    typedef struct {
        logic [3:0] mask;
        int         p1;
        int         p2;
        int         p3;
        int         p4;
        int         exp;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic fill(input int kind, input int from, input bit v);
        for (int k = from; k < MAXC; k++) begin
            case (kind)
                K_READY: exp_ready[k] = v;
                K_DONE:  exp_done[k]  = v;
                K_OVF:   exp_ovf[k]   = v;
                default: exp_perr[k]  = v;
            endcase
        end
    endtask

    // Signed add with wrap; flags results outside the 32-bit signed range.
    function automatic int add_chk(input int x, input int y, inout bit ov);
        longint r;
        r = longint'(x) + longint'(y);
        if (r > 64'sd2147483647 || r < -64'sd2147483648) ov = 1'b1;
        return int'(r);
    endfunction

    // Reference model: lane sum as a pairwise tree, then the running sum.
    task automatic model_beat(input bit v, input bit l, input logic [3:0] mk,
                              input int a, input int b, input int c, input int d);
        int c0;
        int m0, m1, m2, m3, s;
        bit ov;
        c0 = cyc;
        if (!v) return;
        if (!exp_ready[c0]) begin
            fill(K_PERR, c0 + 1, 1'b1);
            return;
        end
        ov = 1'b0;
        m0 = mk[0] ? a : 0;
        m1 = mk[1] ? b : 0;
        m2 = mk[2] ? c : 0;
        m3 = mk[3] ? d : 0;
        s = add_chk(add_chk(m0, m1, ov), add_chk(m2, m3, ov), ov);
        model_acc = add_chk(model_acc, s, ov);
        if (ov) fill(K_OVF, c0 + 2, 1'b1);
        if (l) begin
            wq.push_back('{model_addr, model_acc, c0 + 2});
            model_acc  = 0;
            model_addr = (model_addr + 1) % DEPTH;
            model_count++;
            if (model_count == DEPTH) begin
                fill(K_READY, c0 + 2, 1'b0);
                fill(K_DONE, c0 + 3, 1'b1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic beat(input bit v, input bit l, input logic [3:0] mk,
                        input int a, input int b, input int c, input int d);
        beat_valid = v;
        beat_last  = l;
        lane_mask  = mk;
        mult_1_out = a;
        mult_2_out = b;
        mult_3_out = c;
        mult_4_out = d;
        model_beat(v, l, mk, a, b, c, d);
        tick();
        beat_valid = 1'b0;
        beat_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        fill(K_READY, cyc + 1, 1'b1);
        fill(K_DONE, cyc + 1, 1'b0);
        fill(K_OVF, cyc + 1, 1'b0);
        fill(K_PERR, cyc + 1, 1'b0);
        model_acc   = 0;
        model_addr  = 0;
        model_count = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fill(K_READY, cyc, 1'b0);
        fill(K_DONE, cyc, 1'b0);
        fill(K_OVF, cyc, 1'b0);
        fill(K_PERR, cyc, 1'b0);
        wq.delete();
        model_acc   = 0;
        model_addr  = 0;
        model_count = 0;
        last_addr   = 0;
        last_data   = 0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int rand_product();
        if ($urandom_range(0, 7) == 0) return int'($urandom);
        return int'($urandom_range(0, 2000)) - 1000;
    endfunction

    // Monitor: compares every output once per cycle on the falling edge.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("acc_ready", acc_ready, exp_ready[cyc]);
            chk("done_c", done_c, exp_done[cyc]);
            chk("overflow_c", overflow_c, exp_ovf[cyc]);
            chk("protocol_err", protocol_err, exp_perr[cyc]);
            if (wr_en_c) begin
                if (wq.size() == 0 || wq[0].due != cyc) begin
                    chk("wr_en_c_unexpected", wr_en_c, 1'b0);
                end else begin
                    chk("wr_address_c", wr_address_c, wq[0].addr);
                    chk("write_data_c", write_data_c, wq[0].data);
                    $display("write cyc=%0d addr=%0d data=%08h", cyc, wr_address_c, write_data_c);
                    last_addr = wq[0].addr;
                    last_data = wq[0].data;
                    cap_data[wr_address_c] = write_data_c;
                    void'(wq.pop_front());
                end
            end else begin
                if (wq.size() > 0 && wq[0].due == cyc) begin
                    chk("wr_en_c_missing", wr_en_c, 1'b1);
                    void'(wq.pop_front());
                end
                chk("hold_address", wr_address_c, last_addr);
                chk("hold_data", write_data_c, last_data);
            end
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{4'hF, 1, 2, 3, 4, 10};
        tbl[1] = '{4'hF, 2, 4, 6, 8, 20};
        tbl[2] = '{4'h5, 10, 99, 20, 99, 30};
        tbl[3] = '{4'hA, 99, 15, 99, 25, 40};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle(2);

        // Directed: single beat, two-beat element, masking, empty mask.
        do_start();
        beat(1, 1, 4'hF, 1, 2, 3, 4);
        beat(1, 0, 4'hF, 1, 1, 1, 1);
        beat(1, 1, 4'hF, 2, 2, 2, 2);
        beat(1, 1, 4'b0011, 5, 6, 100, 100);
        beat(1, 1, 4'b0000, 9, 9, 9, 9);
        idle(4);
        chk("tp_single_beat", cap_data[0], 10);
        chk("tp_two_beats", cap_data[1], 12);
        chk("tp_masked", cap_data[2], 11);
        chk("tp_empty_mask", cap_data[3], 0);
        chk("tp_done", done_c, 1'b1);

        // Table: four back-to-back last beats.
        for (int i = 0; i < DEPTH; i++) cap_data[i] = -1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            beat(1, 1, tbl[i].mask, tbl[i].p1, tbl[i].p2, tbl[i].p3, tbl[i].p4);
        end
        idle(4);
        for (int i = 0; i < 4; i++) chk($sformatf("tbl_%0d", i), cap_data[i], tbl[i].exp);

        // Overflow is sticky across elements.
        do_start();
        beat(1, 1, 4'hF, 32'h7FFFFFFF, 1, 0, 0);
        beat(1, 1, 4'hF, 1, 1, 1, 1);
        idle(3);
        chk("ovf_data", cap_data[0], 32'h80000000);
        chk("ovf_next_elem", cap_data[1], 4);
        chk("ovf_sticky", overflow_c, 1'b1);
        beat(1, 1, 4'h0, 0, 0, 0, 0);
        beat(1, 1, 4'h0, 0, 0, 0, 0);
        idle(4);

        // Beat while done: dropped and flagged; start clears the sticky flags.
        beat(1, 1, 4'hF, 5, 5, 5, 5);
        idle(2);
        chk("perr_set", protocol_err, 1'b1);
        do_start();
        idle(1);
        chk("ovf_cleared", overflow_c, 1'b0);
        chk("perr_cleared", protocol_err, 1'b0);

        // Reset between a non-last and a last beat drops the element.
        beat(1, 0, 4'hF, 3, 3, 3, 3);
        do_reset();
        idle(2);
        do_start();
        beat(1, 1, 4'b0111, 1, 2, 4, 9);
        idle(3);
        chk("post_reset_data", cap_data[0], 7);
        chk("post_reset_addr", wr_address_c, 0);
        beat(1, 1, 4'h0, 0, 0, 0, 0);
        beat(1, 1, 4'h0, 0, 0, 0, 0);
        beat(1, 1, 4'h0, 0, 0, 0, 0);
        idle(4);

        // Randomized matrices against the reference model.
        for (int r = 0; r < 8; r++) begin
            do_start();
            for (int e = 0; e < DEPTH; e++) begin
                int nb;
                nb = int'($urandom_range(1, 4));
                for (int b = 0; b < nb; b++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    beat(1, b == nb - 1, 4'($urandom_range(0, 15)),
                         rand_product(), rand_product(), rand_product(), rand_product());
                end
            end
            idle(4);
            chk("rand_done", done_c, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                beat(1, 1, 4'hF, 1, 1, 1, 1);
                idle(1);
            end
        end

        idle(2);
        chk("queue_empty", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
